// File: rtl/switch_pkg.sv
// Shared types and constants for the switch output-port scheduler.
package switch_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned WDOG_CYC_DEF = 64;

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_XFER,
        SCH_DRAIN
    } sched_state_e;

endpackage

// File: rtl/switch_out_sched_if.sv
// Input-queue request/pop bus and output-port pull bus of one switch output.
interface switch_out_sched_if
    import switch_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned DW     = DATA_W
);
    localparam int unsigned IW = $clog2(NUM_IN);

    logic [NUM_IN-1:0]    in_valid;
    logic [NUM_IN*DW-1:0] in_data;
    logic [NUM_IN-1:0]    in_last;
    logic [NUM_IN-1:0]    in_pop;
    logic [DW-1:0]        data;
    logic                 ready;
    logic                 read;
    logic [IW-1:0]        grant_id;
    logic                 busy;

    modport master (
        input  in_valid, in_data, in_last, read,
        output in_pop, data, ready, grant_id, busy
    );

    modport slave (
        output in_valid, in_data, in_last, read,
        input  in_pop, data, ready, grant_id, busy
    );
endinterface

// File: rtl/switch_out_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          any
);
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        win = '0;
        any = 1'b0;
        sum = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_out_sched.sv
// Packet-level round-robin scheduler for one switch output port.
// Optional stall watchdog enabled by defining SWITCH_OUT_SCHED_WDOG_EN.
module switch_out_sched
    import switch_pkg::*;
#(
    parameter int unsigned NUM_IN   = 4,
    parameter int unsigned DW       = DATA_W
`ifdef SWITCH_OUT_SCHED_WDOG_EN
    ,
    parameter int unsigned WDOG_CYC = WDOG_CYC_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    switch_out_sched_if.master  bus
`ifdef SWITCH_OUT_SCHED_WDOG_EN
    ,
    output logic                wdog_err
`endif
);
    localparam int unsigned IW = $clog2(NUM_IN);

    sched_state_e  state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win;
    logic          any_req;
    logic [IW-1:0] ptr_next;
    logic          owner_valid;
    logic          slot_free;
    logic          pop_c;
    logic [DW-1:0] lane [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        assign lane[i] = bus.in_data[i*DW +: DW];
    end

    rr_pick #(.N(NUM_IN), .IW(IW)) u_pick (
        .req (bus.in_valid),
        .ptr (rr_ptr),
        .win (win),
        .any (any_req)
    );

    // The holding register accepts a byte when empty or being emptied this cycle.
    assign slot_free   = !bus.ready || bus.read;
    assign owner_valid = bus.in_valid[bus.grant_id];
    assign pop_c       = (state == SCH_XFER) && slot_free && owner_valid;
    assign bus.in_pop  = pop_c ? (NUM_IN'(1) << bus.grant_id) : '0;
    assign ptr_next    = (bus.grant_id == IW'(NUM_IN - 1)) ? '0 : bus.grant_id + IW'(1);

`ifdef SWITCH_OUT_SCHED_WDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SCH_IDLE;
            rr_ptr       <= '0;
            bus.data     <= '0;
            bus.ready    <= 1'b0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
`ifdef SWITCH_OUT_SCHED_WDOG_EN
            wdog_cnt     <= '0;
            wdog_err     <= 1'b0;
`endif
        end else begin
`ifdef SWITCH_OUT_SCHED_WDOG_EN
            wdog_err <= 1'b0;
`endif
            case (state)
                SCH_IDLE: begin
                    if (any_req) begin
                        bus.grant_id <= win;
                        bus.busy     <= 1'b1;
                        state        <= SCH_XFER;
                    end
                end
                SCH_XFER: begin
                    if (pop_c) begin
                        bus.data  <= lane[bus.grant_id];
                        bus.ready <= 1'b1;
                        if (bus.in_last[bus.grant_id]) begin
                            state <= SCH_DRAIN;
                        end
                    end else if (bus.ready && bus.read) begin
                        bus.ready <= 1'b0;
                    end
`ifdef SWITCH_OUT_SCHED_WDOG_EN
                    // Abort the packet after WDOG_CYC cycles with the owner empty.
                    if (pop_c) begin
                        wdog_cnt <= '0;
                    end else if (!owner_valid) begin
                        if (wdog_cnt == WW'(WDOG_CYC - 1)) begin
                            wdog_err  <= 1'b1;
                            wdog_cnt  <= '0;
                            bus.ready <= 1'b0;
                            bus.busy  <= 1'b0;
                            rr_ptr    <= ptr_next;
                            state     <= SCH_IDLE;
                        end else begin
                            wdog_cnt <= wdog_cnt + WW'(1);
                        end
                    end
`endif
                end
                SCH_DRAIN: begin
                    if (bus.ready && bus.read) begin
                        bus.ready <= 1'b0;
                        bus.busy  <= 1'b0;
                        rr_ptr    <= ptr_next;
                        state     <= SCH_IDLE;
                    end
                end
                default: state <= SCH_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_switch_out_sched.sv
// Directed bench for switch_out_sched with behavioural input queues.
`timescale 1ns/1ps
module tb_switch_out_sched;
    localparam int unsigned N = 4;

    logic clk;
    logic rst_n;
`ifdef SWITCH_OUT_SCHED_WDOG_EN
    logic wdog_err;
`endif

    switch_out_sched_if #(.NUM_IN(N), .DW(8)) bus ();

`ifdef SWITCH_OUT_SCHED_WDOG_EN
    switch_out_sched #(.NUM_IN(N), .DW(8), .WDOG_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .wdog_err(wdog_err));
`else
    switch_out_sched #(.NUM_IN(N), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] qd [N][$];
    bit         ql [N][$];
    bit [N-1:0] hold;
    int         pop_cnt [N];
    logic [7:0] out_q [$];
    logic [7:0] exp_q [$];
    int         gq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.in_valid[i]      = (qd[i].size() != 0) && !hold[i];
            bus.in_data[i*8 +: 8] = (qd[i].size() != 0) ? qd[i][0] : 8'h00;
            bus.in_last[i]       = (ql[i].size() != 0) ? ql[i][0] : 1'b0;
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic push_pkt(input int q, input logic [7:0] base, input int len);
        for (int b = 0; b < len; b++) begin
            qd[q].push_back(base + 8'(b));
            ql[q].push_back(b == len - 1);
        end
    endtask

    task automatic exp_pkt(input logic [7:0] base, input int len);
        for (int b = 0; b < len; b++) exp_q.push_back(base + 8'(b));
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            qd[i].delete();
            ql[i].delete();
            pop_cnt[i] = 0;
        end
        hold = '0;
        out_q.delete();
        exp_q.delete();
        gq.delete();
    endtask

    // One clock: sample pops/reads before the edge, apply them after it.
    task automatic tick();
        logic [N-1:0] p;
        logic         took;
        logic [7:0]   d;
        logic         b0;
        p    = bus.in_pop;
        took = bus.ready && bus.read;
        d    = bus.data;
        b0   = bus.busy;
        if (p != '0) chk("pop_owner", 32'(p), 32'(1) << bus.grant_id);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
                pop_cnt[i]++;
            end
        end
        if (took) out_q.push_back(d);
        @(negedge clk);
        if (bus.busy && !b0) gq.push_back(int'(bus.grant_id));
        settle();
    endtask

    task automatic run_idle(input string tag, input int maxc);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxc && !done; c++) begin
            tick();
            if (bus.in_valid == '0 && !bus.busy && !bus.ready) done = 1'b1;
        end
        if (!done) chk({tag, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < out_q.size()) chk({tag, "_byte"}, 32'(out_q[k]), 32'(exp_q[k]));
        end
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        settle();
    endtask

    initial begin
        logic [7:0] held;
        bit         watch;
        rst_n    = 1'b0;
        bus.read = 1'b0;
        clear_all();
        drive();
        #2;
        chk("rst_ready", 32'(bus.ready), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_pop", 32'(bus.in_pop), 32'(0));
        chk("rst_grant", 32'(bus.grant_id), 32'(0));
        chk("rst_data", 32'(bus.data), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        settle();

        // Single 3-byte packet on input 0 with read held high.
        push_pkt(0, 8'hA1, 3);
        exp_pkt(8'hA1, 3);
        bus.read = 1'b1;
        settle();
        chk("t1_idle_busy", 32'(bus.busy), 32'(0));
        chk("t1_idle_pop", 32'(bus.in_pop), 32'(0));
        tick();
        chk("t1_grant_busy", 32'(bus.busy), 32'(1));
        chk("t1_grant_id", 32'(bus.grant_id), 32'(0));
        chk("t1_grant_ready", 32'(bus.ready), 32'(0));
        chk("t1_first_pop", 32'(bus.in_pop), 32'(1));
        tick();
        chk("t1_ready", 32'(bus.ready), 32'(1));
        chk("t1_d0", 32'(bus.data), 32'(8'hA1));
        tick();
        chk("t1_d1", 32'(bus.data), 32'(8'hA2));
        tick();
        chk("t1_d2", 32'(bus.data), 32'(8'hA3));
        chk("t1_drain_busy", 32'(bus.busy), 32'(1));
        tick();
        chk("t1_end_busy", 32'(bus.busy), 32'(0));
        chk("t1_end_ready", 32'(bus.ready), 32'(0));
        chk("t1_pops", 32'(pop_cnt[0]), 32'(3));
        check_out("t1");

        // Fairness: every input holds two 2-byte packets.
        do_reset();
        clear_all();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                push_pkt(i, 8'(8'h10 * (i + 1) + p * 4), 2);
                exp_pkt(8'(8'h10 * (i + 1) + p * 4), 2);
            end
        end
        settle();
        run_idle("t2", 80);
        chk("t2_ngrants", 32'(gq.size()), 32'(8));
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) chk("t2_grant_seq", 32'(gq[k]), 32'(k % 4));
        end
        check_out("t2");

        // Backpressure: read pattern 1,0,0,1 once data is flowing.
        clear_all();
        push_pkt(3, 8'hB0, 4);
        exp_pkt(8'hB0, 4);
        for (int c = 0; c < 30; c++) begin
            bus.read = !(c == 3 || c == 4);
            settle();
            watch = bus.ready && !bus.read;
            held  = bus.data;
            if (watch) chk("t3_no_pop_stall", 32'(bus.in_pop), 32'(0));
            tick();
            if (watch) chk("t3_data_held", 32'(bus.data), 32'(held));
            if (c > 0 && bus.in_valid == '0 && !bus.busy && !bus.ready) break;
        end
        bus.read = 1'b1;
        settle();
        chk("t3_pops", 32'(pop_cnt[3]), 32'(4));
        chk("t3_idle", 32'(bus.busy), 32'(0));
        check_out("t3");

        // Owner stall: input 2 owns, input 1 waits during a 5-cycle gap.
        clear_all();
        push_pkt(2, 8'hC0, 4);
        exp_pkt(8'hC0, 4);
        settle();
        tick();
        chk("t4_grant", 32'(bus.grant_id), 32'(2));
        push_pkt(1, 8'hD0, 2);
        exp_pkt(8'hD0, 2);
        settle();
        tick();
        tick();
        chk("t4_pops_before", 32'(pop_cnt[2]), 32'(2));
        hold[2] = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk("t4_stall_grant", 32'(bus.grant_id), 32'(2));
            chk("t4_stall_pop", 32'(bus.in_pop), 32'(0));
            tick();
        end
        chk("t4_stall_ready", 32'(bus.ready), 32'(0));
        chk("t4_stall_busy", 32'(bus.busy), 32'(1));
        gq.delete();
        hold[2] = 1'b0;
        settle();
        run_idle("t4", 40);
        chk("t4_next_n", 32'(gq.size()), 32'(1));
        if (gq.size() > 0) chk("t4_next_grant", 32'(gq[0]), 32'(1));
        check_out("t4");

        // Reset in the middle of a 5-byte packet from input 3.
        clear_all();
        push_pkt(3, 8'hE0, 5);
        settle();
        tick();
        chk("t5_grant", 32'(bus.grant_id), 32'(3));
        tick();
        tick();
        chk("t5_pops_before", 32'(pop_cnt[3]), 32'(2));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(bus.ready), 32'(0));
        chk("t5_rst_busy", 32'(bus.busy), 32'(0));
        chk("t5_rst_pop", 32'(bus.in_pop), 32'(0));
        clear_all();
        @(negedge clk);
        rst_n = 1'b1;
        push_pkt(3, 8'hF0, 1);
        push_pkt(1, 8'hF8, 1);
        exp_pkt(8'hF8, 1);
        exp_pkt(8'hF0, 1);
        settle();
        run_idle("t5", 40);
        chk("t5_ngrants", 32'(gq.size()), 32'(2));
        if (gq.size() > 1) begin
            chk("t5_first_grant", 32'(gq[0]), 32'(1));
            chk("t5_second_grant", 32'(gq[1]), 32'(3));
        end
        check_out("t5");

`ifdef SWITCH_OUT_SCHED_WDOG_EN
        // Watchdog: owner 0 stalls after its first byte; input 2 takes over.
        begin
            int errs;
            int first;
            clear_all();
            chk("t6_err_idle", 32'(wdog_err), 32'(0));
            push_pkt(0, 8'h70, 3);
            exp_pkt(8'h70, 1);
            settle();
            tick();
            push_pkt(2, 8'h78, 1);
            exp_pkt(8'h78, 1);
            settle();
            tick();
            hold[0] = 1'b1;
            settle();
            errs  = 0;
            first = -1;
            for (int k = 1; k <= 14; k++) begin
                tick();
                if (wdog_err) begin
                    errs++;
                    if (first < 0) begin
                        first = k;
                        chk("t6_busy_abort", 32'(bus.busy), 32'(0));
                        chk("t6_ready_abort", 32'(bus.ready), 32'(0));
                    end
                end
            end
            chk("t6_err_pulses", 32'(errs), 32'(1));
            chk("t6_err_cycle", 32'(first), 32'(8));
            qd[0].delete();
            ql[0].delete();
            settle();
            run_idle("t6", 40);
            chk("t6_ngrants", 32'(gq.size()), 32'(2));
            if (gq.size() > 1) chk("t6_next_grant", 32'(gq[1]), 32'(2));
            check_out("t6");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/switch_out_sched.md
Name: switch_out_sched

Overview:
- Packet-level round-robin scheduler for one switch output port.
- Shares the port between NUM_IN input-queue requesters.
- Drives the output-port pull interface: data, ready, read.
- A granted input holds the port until its last byte is read out; one output holding register gives zero-bubble streaming.

Parameters:
- NUM_IN, 4, number of requesting input queues (2..8).
- DW, 8, data width; fixed to 8 to match the output-port data bus.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_IN  queue i has a byte available at its head.
- in_data  input  NUM_IN*DW  head byte of queue i, in slice [i*DW +: DW].
- in_last  input  NUM_IN  head byte of queue i is the final byte of its packet.
- in_pop  output  NUM_IN  one-hot pop pulse: dequeue the head of queue i this cycle.
- data  output  DW  output-port data (holding register).
- ready  output  1  data holds a valid byte.
- read  input  1  consumer takes data this cycle; honoured only when ready=1.
- grant_id  output  $clog2(NUM_IN)  index of the current owner; valid while busy=1.
- busy  output  1  a packet is in progress.

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, ready=0, data=0, in_pop=0, grant_id=0, busy=0, rr_ptr=0.
- Free slot: `slot_free = !ready || (ready && read)`.
- IDLE:
  - If any in_valid, the winner is the first set bit searching from rr_ptr upward with wrap.
  - Register grant_id=winner, busy=1, go to XFER. No pop this cycle.
  - If no in_valid, stay in IDLE.
- XFER:
  - If `slot_free && in_valid[grant_id]`: in_pop[grant_id]=1 (combinational); data<=in_data[grant_id]; ready<=1; last_q<=in_last[grant_id].
  - If `ready && read` and no load occurs: ready<=0.
  - If in_last[grant_id] is popped: go to DRAIN. No further pops for this packet.
- DRAIN:
  - Wait until the last byte is read (`ready && read`), then: ready<=0, rr_ptr<=grant_id+1 (mod NUM_IN), busy<=0, go to IDLE.
  - The next arbitration happens the following cycle.
- Latency:
  - Requester valid in IDLE at cycle 0 -> grant at edge 1 -> first pop in cycle 1 -> ready=1 after edge 2.
  - Back-to-back bytes within a packet have no bubble when read is held high.
  - Packet-to-packet gap is 2 cycles (DRAIN exit, IDLE arbitration).
- in_valid of the owner dropping mid-packet: hold the grant and wait. No pop; ready falls after the current byte is read.
- Non-owners are never popped. Their in_valid is ignored until IDLE.
- read while ready=0: ignored, no side effects.
- Single-byte packet: pop with in_last -> DRAIN directly.
- rst_n asserted mid-packet: all state cleared immediately. A partially sent packet is abandoned; the queues own any cleanup.
- in_pop is at most one-hot, and is zero in IDLE and DRAIN.

Optional Feature:
- Macro: SWITCH_OUT_SCHED_WDOG_EN.
- When defined:
  - Adds parameter WDOG_CYC (default 64).
  - Adds output wdog_err (1 bit, reset 0).
  - A counter runs in XFER whenever in_valid[grant_id]=0; it clears on every pop.
  - On reaching WDOG_CYC, wdog_err pulses high for one cycle and the packet is aborted: ready<=0, rr_ptr<=grant_id+1, go to IDLE.
- When undefined: no counter and no wdog_err port; a stalled owner holds the port indefinitely.

Decomposition:
- Package switch_pkg holds:
  - DATA_W=8;
  - typedef enum logic [1:0] {SCH_IDLE, SCH_XFER, SCH_DRAIN} sched_state_e;
  - default WDOG_CYC constant.
- One sub-module, rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req vector, ptr. Outputs: winner index, any.

Test Plan:
- Single packet: input 0 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), read held 1 -> ready first high 2 cycles after valid; bytes out in order on consecutive cycles; in_pop[0] pulses 3 times; busy falls after 0xA3 is read.
- Fairness: all 4 inputs continuously valid with 2-byte packets -> grant_id sequence 0,1,2,3,0; no interleaving of bytes between packets.
- Backpressure: read toggled 1,0,0,1 during a 4-byte packet -> data held stable while read=0; no pop while ready=1 and read=0; no byte lost or duplicated.
- Owner stall: input 2 drops in_valid for 5 cycles mid-packet while input 1 is valid -> grant stays 2; in_pop[1]=0 throughout; the packet completes after resume.
- Reset mid-packet: assert rst_n=0 after 2 of 5 bytes -> ready=0, busy=0, in_pop=0 immediately; after release, a fresh arbitration starts from input 0.
- With SWITCH_OUT_SCHED_WDOG_EN and WDOG_CYC=8: owner stalls 8 cycles -> wdog_err pulses once; busy=0 next cycle; the next requester is granted.
